// File: rtl/ct_lsu_cache_buffer_mentry.sv
// Multi-entry load cache buffer: holds recently read dcache lines so a DC-stage
// lookup hit can deliver line data in DA without a dcache data read.
module ct_lsu_cache_buffer_mentry #(
    parameter int unsigned ENTRY_NUM  = 4,
    parameter int unsigned PA_WIDTH   = 40,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned IDX_LSB    = 2
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  cp0_lsu_icg_en,
    input  logic                  cp0_yy_clk_en,
    input  logic                  pad_yy_icg_scan_en,
    input  logic                  cp0_lsu_dcache_en,
    input  logic                  cp0_lsu_cb_aclr_dis,
    input  logic                  cp0_lsu_no_op_req,
    input  logic                  icc_idle,
    input  logic [8:0]            dcache_idx,
    input  logic                  lsu_dcache_ld_xx_gwen,
    input  logic                  ld_dc_inst_vld,
    input  logic [PA_WIDTH-1:0]   ld_dc_addr1,
    input  logic                  ld_dc_cb_addr_create_vld,
    input  logic                  ld_dc_cb_addr_create_gateclk_en,
    input  logic [PA_WIDTH-5:0]   ld_dc_cb_addr_tto4,
    input  logic                  ld_da_cb_data_vld,
    input  logic [DATA_WIDTH-1:0] ld_da_cb_data,
    input  logic                  ld_da_cb_ecc_cancel,
    output logic                  cb_ld_dc_addr_hit,
    output logic                  cb_ld_da_data_vld,
    output logic [DATA_WIDTH-1:0] cb_ld_da_data,
    output logic [ENTRY_NUM-1:0]  cb_ld_da_hit_entry,
    output logic [ENTRY_NUM-1:0]  cb_entry_vld
);

    localparam int unsigned TAG_W = PA_WIDTH - 4;
    localparam int unsigned PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    typedef enum logic [1:0] {
        ST_INVALID = 2'b00,
        ST_PEND    = 2'b01,
        ST_VALID   = 2'b10
    } state_e;

    state_e                state_q [ENTRY_NUM];
    state_e                state_d [ENTRY_NUM];
    logic [TAG_W-1:0]      tag_q   [ENTRY_NUM];
    logic [DATA_WIDTH-1:0] data_q  [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]  hit_q, hit_d;
    logic [PTR_W-1:0]      rr_q, rr_d;

    logic                  flush;
    logic                  alloc;
    logic                  fill_ok;
    logic                  tag_clk_on;
    logic                  data_clk_on;
    logic [ENTRY_NUM-1:0]  vld_vec;
    logic [ENTRY_NUM-1:0]  pend_vec;
    logic [ENTRY_NUM-1:0]  inv_vec;
    logic [ENTRY_NUM-1:0]  reuse_vec;
    logic [ENTRY_NUM-1:0]  idx_hit_vec;
    logic [ENTRY_NUM-1:0]  victim_first;
    logic [ENTRY_NUM-1:0]  victim_vec;
    logic                  unused_bits_c;

    assign unused_bits_c = ^{dcache_idx[8], ld_dc_addr1[3:0]};

    assign flush   = !cp0_lsu_dcache_en | cp0_lsu_cb_aclr_dis | cp0_lsu_no_op_req | !icc_idle;
    assign alloc   = ld_dc_cb_addr_create_vld & !cp0_lsu_cb_aclr_dis;
    assign fill_ok = ld_da_cb_data_vld & !ld_da_cb_ecc_cancel;

    // Clock-gate enables: global enable with module/local enable, scan forces on
    assign tag_clk_on  = (cp0_yy_clk_en & (cp0_lsu_icg_en
                         | (ld_dc_cb_addr_create_gateclk_en & !cp0_lsu_cb_aclr_dis)))
                         | pad_yy_icg_scan_en;
    assign data_clk_on = (cp0_yy_clk_en & (cp0_lsu_icg_en
                         | (ld_da_cb_data_vld & !cp0_lsu_cb_aclr_dis)))
                         | pad_yy_icg_scan_en;

    always_comb begin
        vld_vec     = '0;
        pend_vec    = '0;
        inv_vec     = '0;
        reuse_vec   = '0;
        idx_hit_vec = '0;
        hit_d       = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            vld_vec[i]     = (state_q[i] == ST_VALID);
            pend_vec[i]    = (state_q[i] == ST_PEND);
            inv_vec[i]     = (state_q[i] == ST_INVALID);
            reuse_vec[i]   = !inv_vec[i] && (tag_q[i] == ld_dc_cb_addr_tto4);
            idx_hit_vec[i] = lsu_dcache_ld_xx_gwen
                             && (tag_q[i][IDX_LSB+7:IDX_LSB] == dcache_idx[7:0]);
            hit_d[i]       = ld_dc_inst_vld && vld_vec[i]
                             && (tag_q[i] == ld_dc_addr1[PA_WIDTH-1:4]);
        end
    end

    // Victim: matching tag, else lowest INVALID entry, else round-robin pointer
    always_comb begin
        victim_first = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (inv_vec[i]) begin
                victim_first    = '0;
                victim_first[i] = 1'b1;
            end
        end
        rr_d = rr_q;
        if (|reuse_vec) begin
            victim_vec = reuse_vec;
        end else if (|inv_vec) begin
            victim_vec = victim_first;
        end else begin
            victim_vec = ENTRY_NUM'(1) << rr_q;
            if (alloc && !flush) begin
                rr_d = rr_q + PTR_W'(1);
            end
        end
    end

    // Per-entry next state; invalidation sources outrank allocation and fill
    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            state_d[i] = state_q[i];
            if (flush) begin
                state_d[i] = ST_INVALID;
            end else if (idx_hit_vec[i]) begin
                state_d[i] = ST_INVALID;
            end else if (ld_da_cb_ecc_cancel && hit_q[i]) begin
                state_d[i] = ST_INVALID;
            end else if (alloc && victim_vec[i]) begin
                state_d[i] = ST_PEND;
            end else if (pend_vec[i]) begin
                state_d[i] = fill_ok ? ST_VALID : ST_INVALID;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= ST_INVALID;
            end
            hit_q <= '0;
            rr_q  <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= state_d[i];
            end
            hit_q <= flush ? '0 : hit_d;
            rr_q  <= rr_d;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (tag_clk_on && alloc && victim_vec[i]) begin
                    tag_q[i] <= ld_dc_cb_addr_tto4;
                end
                if (data_clk_on && fill_ok && pend_vec[i]) begin
                    data_q[i] <= ld_da_cb_data;
                end
            end
        end
    end

    assign cb_ld_dc_addr_hit  = |hit_d;
    assign cb_ld_da_hit_entry = hit_q & vld_vec;
    assign cb_ld_da_data_vld  = (|cb_ld_da_hit_entry) & !ld_da_cb_ecc_cancel;
    assign cb_entry_vld       = vld_vec;

    always_comb begin
        cb_ld_da_data = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (cb_ld_da_hit_entry[i]) begin
                cb_ld_da_data = cb_ld_da_data | data_q[i];
            end
        end
    end

endmodule

// File: tb/tb_ct_lsu_cache_buffer_mentry.sv
// Directed, table-driven bench for the multi-entry load cache buffer.
module tb_ct_lsu_cache_buffer_mentry;

    localparam int unsigned EN = 4;
    localparam int unsigned PA = 40;
    localparam int unsigned DW = 128;
    localparam int unsigned TW = PA - 4;

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic          icg_en, clk_en, scan_en;
    logic          dcache_en, aclr_dis, no_op;
    logic          icc_idle;
    logic [8:0]    dcache_idx;
    logic          gwen;
    logic          inst_vld;
    logic [PA-1:0] addr1;
    logic          create_vld, create_gclk;
    logic [TW-1:0] create_tag;
    logic          data_vld;
    logic [DW-1:0] fill_data;
    logic          ecc;
    logic          dc_hit;
    logic          da_vld;
    logic [DW-1:0] da_data;
    logic [EN-1:0] da_he;
    logic [EN-1:0] entry_vld;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ct_lsu_cache_buffer_mentry #(
        .ENTRY_NUM(EN), .PA_WIDTH(PA), .DATA_WIDTH(DW), .IDX_LSB(2)
    ) dut (
        .forever_cpuclk                  (clk),
        .cpurst_b                        (cpurst_b),
        .cp0_lsu_icg_en                  (icg_en),
        .cp0_yy_clk_en                   (clk_en),
        .pad_yy_icg_scan_en              (scan_en),
        .cp0_lsu_dcache_en               (dcache_en),
        .cp0_lsu_cb_aclr_dis             (aclr_dis),
        .cp0_lsu_no_op_req               (no_op),
        .icc_idle                        (icc_idle),
        .dcache_idx                      (dcache_idx),
        .lsu_dcache_ld_xx_gwen           (gwen),
        .ld_dc_inst_vld                  (inst_vld),
        .ld_dc_addr1                     (addr1),
        .ld_dc_cb_addr_create_vld        (create_vld),
        .ld_dc_cb_addr_create_gateclk_en (create_gclk),
        .ld_dc_cb_addr_tto4              (create_tag),
        .ld_da_cb_data_vld               (data_vld),
        .ld_da_cb_data                   (fill_data),
        .ld_da_cb_ecc_cancel             (ecc),
        .cb_ld_dc_addr_hit               (dc_hit),
        .cb_ld_da_data_vld               (da_vld),
        .cb_ld_da_data                   (da_data),
        .cb_ld_da_hit_entry              (da_he),
        .cb_entry_vld                    (entry_vld)
    );

    typedef struct {
        string         nm;
        logic          cr;
        logic [TW-1:0] ctag;
        logic          dv;
        logic [DW-1:0] d;
        logic          ecc;
        logic          lk;
        logic [TW-1:0] ltag;
        logic          gw;
        logic [8:0]    idx;
        logic          idle;
        logic          e_hit;
        logic          e_dv;
        logic [DW-1:0] e_d;
        logic [EN-1:0] e_he;
        logic [EN-1:0] e_ev;
    } vec_t;

    vec_t tbl[$];

    localparam logic [DW-1:0] DA = {16{8'hA5}};
    localparam logic [DW-1:0] D1 = {8{16'h1111}};
    localparam logic [DW-1:0] D2 = {8{16'h2222}};
    localparam logic [DW-1:0] D3 = {8{16'h3333}};
    localparam logic [DW-1:0] D4 = {8{16'h4444}};
    localparam logic [DW-1:0] D5 = {8{16'h5555}};
    localparam logic [DW-1:0] D6 = {8{16'h6666}};
    localparam logic [DW-1:0] D7 = {8{16'h7777}};
    localparam logic [DW-1:0] D8 = {8{16'h8888}};
    localparam logic [DW-1:0] D9 = {8{16'h9999}};
    localparam logic [DW-1:0] DB = {8{16'h2323}};
    localparam logic [DW-1:0] Z  = '0;

    localparam logic [TW-1:0] T0 = 36'h123456780;
    localparam logic [TW-1:0] TA = 36'h10;
    localparam logic [TW-1:0] TB = 36'h20;
    localparam logic [TW-1:0] TC = 36'h30;
    localparam logic [TW-1:0] TD = 36'h40;
    localparam logic [TW-1:0] TE = 36'h50;
    localparam logic [TW-1:0] TF = 36'h60;
    localparam logic [TW-1:0] TG = 36'hF0;
    localparam logic [TW-1:0] TH = 36'h100;
    localparam logic [TW-1:0] TR = 36'h777;

    function automatic vec_t mk(string nm, logic cr, logic [TW-1:0] ctag, logic dv,
                                logic [DW-1:0] d, logic ec, logic lk, logic [TW-1:0] ltag,
                                logic gw, logic [8:0] idx, logic idle, logic e_hit,
                                logic e_dv, logic [DW-1:0] e_d, logic [EN-1:0] e_he,
                                logic [EN-1:0] e_ev);
        vec_t r;
        r.nm = nm; r.cr = cr; r.ctag = ctag; r.dv = dv; r.d = d; r.ecc = ec;
        r.lk = lk; r.ltag = ltag; r.gw = gw; r.idx = idx; r.idle = idle;
        r.e_hit = e_hit; r.e_dv = e_dv; r.e_d = e_d; r.e_he = e_he; r.e_ev = e_ev;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        create_vld  = r.cr;
        create_gclk = r.cr;
        create_tag  = r.ctag;
        data_vld    = r.dv;
        fill_data   = r.d;
        ecc         = r.ecc;
        inst_vld    = r.lk;
        addr1       = {r.ltag, 4'h0};
        gwen        = r.gw;
        dcache_idx  = r.idx;
        icc_idle    = r.idle;
    endtask

    task automatic check(input string nm, input logic e_hit, input logic e_dv,
                         input logic [DW-1:0] e_d, input logic [EN-1:0] e_he,
                         input logic [EN-1:0] e_ev);
        n_cmp++;
        if ({dc_hit, da_vld, da_data, da_he, entry_vld} !== {e_hit, e_dv, e_d, e_he, e_ev}) begin
            n_bad++;
            $display("FAIL %s: got hit=%b dv=%b data=%h he=%b ev=%b, want hit=%b dv=%b data=%h he=%b ev=%b",
                     nm, dc_hit, da_vld, da_data, da_he, entry_vld,
                     e_hit, e_dv, e_d, e_he, e_ev);
        end
    endtask

    initial begin
        cpurst_b = 1'b0;
        icg_en = 1'b0; clk_en = 1'b1; scan_en = 1'b0;
        dcache_en = 1'b1; aclr_dis = 1'b0; no_op = 1'b0;
        drive(mk("init", 0, 0, 0, Z, 0, 1, T0, 0, 9'h0, 1, 0, 0, Z, 4'h0, 4'h0));

        //                 name         cr ctag dv data ec lk ltag gw idx    idle hit dv edata he       ev
        // basic allocate / fill / hit
        tbl.push_back(mk("idle0",       0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("alloc_t0",    1, T0, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("fill_t0",     0, 0,  1, DA, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("t0_valid",    0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("lookup_t0",   0, 0,  0, Z,  0, 1, T0, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("da_t0",       0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  1, DA, 4'b0001, 4'b0001));
        tbl.push_back(mk("quiet0",      0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("flush_a",     0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  0,   0,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("flush_b",     0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        // fill all entries in order, then round-robin replacement
        tbl.push_back(mk("alloc_a",     1, TA, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("fill_a",      0, 0,  1, D1, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("alloc_b",     1, TB, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("fill_b",      0, 0,  1, D2, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("alloc_c",     1, TC, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0011));
        tbl.push_back(mk("fill_c",      0, 0,  1, D3, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0011));
        tbl.push_back(mk("alloc_d",     1, TD, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0111));
        tbl.push_back(mk("fill_d",      0, 0,  1, D4, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0111));
        tbl.push_back(mk("alloc_e",     1, TE, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("fill_e_rr0",  0, 0,  1, D5, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1110));
        tbl.push_back(mk("lk_a_miss",   0, 0,  0, Z,  0, 1, TA, 0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("lk_b_hit",    0, 0,  0, Z,  0, 1, TB, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("lk_e_da_b",   0, 0,  0, Z,  0, 1, TE, 0, 9'h0,  1,   1,  1, D2, 4'b0010, 4'b1111));
        tbl.push_back(mk("lk_d_da_e",   0, 0,  0, Z,  0, 1, TD, 0, 9'h0,  1,   1,  1, D5, 4'b0001, 4'b1111));
        tbl.push_back(mk("da_d",        0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  1, D4, 4'b1000, 4'b1111));
        tbl.push_back(mk("alloc_f",     1, TF, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("fill_f_rr1",  0, 0,  1, D6, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1101));
        tbl.push_back(mk("lk_b_gone",   0, 0,  0, Z,  0, 1, TB, 0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("lk_f_hit",    0, 0,  0, Z,  0, 1, TF, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("da_f",        0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  1, D6, 4'b0010, 4'b1111));
        // index invalidate of entry 2 (tag[9:2] = 0x3C)
        tbl.push_back(mk("alloc_g",     1, TG, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("fill_g_rr2",  0, 0,  1, D7, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("gwen_3c",     0, 0,  0, Z,  0, 0, 0,  1, 9'h03C,1,   0,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("lk_g_miss",   0, 0,  0, Z,  0, 1, TG, 0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("lk_e_kept",   0, 0,  0, Z,  0, 1, TE, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("da_e_kept",   0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  1, D5, 4'b0001, 4'b1011));
        // allocate without fill, and fill cancelled by ECC
        tbl.push_back(mk("alloc_h",     1, TH, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("h_no_data",   0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("h_dropped",   0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("alloc_h2",    1, TH, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("h_ecc_fill",  0, 0,  1, D8, 1, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("lk_h_miss",   0, 0,  0, Z,  0, 1, TH, 0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        // all four valid, then one flush cycle with a DA hit pending
        tbl.push_back(mk("alloc_h3",    1, TH, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("fill_h",      0, 0,  1, D8, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b1011));
        tbl.push_back(mk("lk_h_hit",    0, 0,  0, Z,  0, 1, TH, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b1111));
        tbl.push_back(mk("icc_busy",    0, 0,  0, Z,  0, 1, TD, 0, 9'h0,  0,   1,  1, D8, 4'b0100, 4'b1111));
        tbl.push_back(mk("after_flush", 0, 0,  0, Z,  0, 1, TD, 0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("quiet1",      0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        // DA hit survives a same-cycle index invalidate
        tbl.push_back(mk("alloc_g2",    1, TG, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("fill_g2",     0, 0,  1, D9, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("lk_g2_hit",   0, 0,  0, Z,  0, 1, TG, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("da_g2_gwen",  0, 0,  0, Z,  0, 0, 0,  1, 9'h03C,1,   0,  1, D9, 4'b0001, 4'b0001));
        tbl.push_back(mk("g2_gone",     0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        // ECC cancel on a DA hit drops the output and the entry
        tbl.push_back(mk("alloc_a2",    1, TA, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("fill_a2",     0, 0,  1, D1, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("lk_a2_hit",   0, 0,  0, Z,  0, 1, TA, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("da_a2_ecc",   0, 0,  0, Z,  1, 0, 0,  0, 9'h0,  1,   0,  0, D1, 4'b0001, 4'b0001));
        tbl.push_back(mk("a2_ecc_inv",  0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        // re-allocating a resident tag reuses its entry
        tbl.push_back(mk("alloc_b2",    1, TB, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("fill_b2",     0, 0,  1, D2, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("realloc_b2",  1, TB, 0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("refill_b2",   0, 0,  1, DB, 0, 0, 0,  0, 9'h0,  1,   0,  0, Z,  4'b0000, 4'b0000));
        tbl.push_back(mk("lk_b2_hit",   0, 0,  0, Z,  0, 1, TB, 0, 9'h0,  1,   1,  0, Z,  4'b0000, 4'b0001));
        tbl.push_back(mk("da_b2_new",   0, 0,  0, Z,  0, 0, 0,  0, 9'h0,  1,   0,  1, DB, 4'b0001, 4'b0001));

        #3;
        check("in_reset", 1'b0, 1'b0, Z, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        cpurst_b = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(negedge clk);
            check(tbl[k].nm, tbl[k].e_hit, tbl[k].e_dv, tbl[k].e_d, tbl[k].e_he, tbl[k].e_ev);
            @(posedge clk); #1;
        end

        // Asynchronous reset while an entry is PEND; the fill must not land afterwards
        drive(mk("rst_alloc", 1, TR, 0, Z, 0, 0, 0, 0, 9'h0, 1, 0, 0, Z, 4'h0, 4'h0));
        @(posedge clk); #1;
        drive(mk("rst_fill", 0, 0, 1, DA, 0, 0, 0, 0, 9'h0, 1, 0, 0, Z, 4'h0, 4'h0));
        #2;
        cpurst_b = 1'b0;
        #1;
        check("rst_async", 1'b0, 1'b0, Z, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        cpurst_b = 1'b1;
        @(negedge clk);
        check("rst_release", 1'b0, 1'b0, Z, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        drive(mk("rst_lookup", 0, 0, 0, Z, 0, 1, TR, 0, 9'h0, 1, 0, 0, Z, 4'h0, 4'h0));
        @(negedge clk);
        check("rst_no_fill", 1'b0, 1'b0, Z, 4'b0000, 4'b0000);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
